// File: rtl/uart_tx_frame_pkg.sv
// Shared UART line definitions: FSM state encoding, baud divisor computation
// and legal-range checks for character width and stop-bit count.
package uart_tx_frame_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } uart_state_e;

   localparam int unsigned MinDivisor = 4;

   // Clock cycles per line bit, truncating.
   function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                                input int unsigned baud);
      return clk_hz / baud;
   endfunction

   function automatic bit data_bits_legal(input int unsigned n);
      return (n >= 5) && (n <= 9);
   endfunction

   function automatic bit stop_bits_legal(input int unsigned n);
      return (n == 1) || (n == 2);
   endfunction

   function automatic bit fifo_depth_legal(input int unsigned n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIVISOR-1 and pulses tick for one cycle at the
// top of the range. A synchronous clear realigns the period to a new frame.
module uart_baud_tick #(
   parameter int unsigned DIVISOR = 10
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CntW = $clog2(DIVISOR);
   localparam logic [CntW-1:0] LastCnt = CntW'(DIVISOR - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == LastCnt);
      cnt_d = cnt_q + CntW'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with TX FIFO, 5..9 data bits and 1 or 2 stop bits.
// Optional parity bit when UART_TX_FRAME_PARITY_EN is defined.
module uart_tx_frame
   import uart_tx_frame_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 1_000_000,
   parameter int unsigned BAUD_RATE       = 9600,
   parameter int unsigned DATA_BITS       = 8,
   parameter int unsigned STOP_BITS       = 1,
   parameter int unsigned PARITY_ODD      = 0,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                          Clk,
   input  logic                          Reset,
   output logic                          TxWire,
   input  logic [DATA_BITS-1:0]          TxDataInput,
   input  logic                          TxValid,
   output logic                          TxReady,
   output logic                          TxBusy,
   output logic [$clog2(FIFO_DEPTH):0]   TxFifoCount
);

   localparam int unsigned DIVISOR = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE);
   localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned PtrW    = AddrW + 1;
   localparam logic [3:0]  LastBit  = 4'(DATA_BITS - 1);
   localparam logic [3:0]  LastStop = 4'(STOP_BITS - 1);

   if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (!fifo_depth_legal(FIFO_DEPTH)) begin : g_bad_depth
      $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
   end
   if (DIVISOR < MinDivisor) begin : g_bad_divisor
      $error("uart_tx_frame: CLOCK_FREQUENCY / BAUD_RATE must be >= 4");
   end
   if (PARITY_ODD > 1) begin : g_bad_parity
      $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
   end

   // ---------------------------------------------------------------- FIFO
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [PtrW-1:0]      fifo_count;
   logic                 fifo_full, fifo_empty;
   logic                 push, pop;
   logic [DATA_BITS-1:0] fifo_head;

   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   // Same slot, opposite lap: the writer is a whole buffer ahead.
   assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                       (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
   assign push       = TxValid && !fifo_full;
   assign fifo_head  = mem[rd_ptr_q[AddrW-1:0]];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr_q[AddrW-1:0]] <= TxDataInput;
      end
   end

   // ---------------------------------------------------------- baud timing
   logic tick;

   uart_baud_tick #(
      .DIVISOR (DIVISOR)
   ) u_baud_tick (
      .Clk   (Clk),
      .Reset (Reset),
      .clear (pop),
      .tick  (tick)
   );

   // ----------------------------------------------------------------- FSM
   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 line_q, line_d;

`ifdef UART_TX_FRAME_PARITY_EN
   logic parity_q, parity_d;

   always_comb begin
      parity_d = parity_q;
      if (pop) begin
         parity_d = (^fifo_head) ^ (PARITY_ODD != 0);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      line_d    = line_q;
      pop       = 1'b0;
      unique case (state_q)
         StIdle: begin
            line_d = 1'b1;
            pop    = !fifo_empty;
         end
         StStart: begin
            if (tick) begin
               state_d = StData;
               line_d  = shift_q[0];
            end
         end
         StData: begin
            if (tick) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_FRAME_PARITY_EN
                  state_d = StParity;
                  line_d  = parity_q;
`else
                  state_d = StStop;
                  line_d  = 1'b1;
`endif
                  bit_cnt_d = '0;
               end else begin
                  line_d = shift_q[1];
               end
            end
         end
`ifdef UART_TX_FRAME_PARITY_EN
         StParity: begin
            if (tick) begin
               state_d = StStop;
               line_d  = 1'b1;
            end
         end
`endif
         StStop: begin
            if (tick) begin
               if (bit_cnt_q == LastStop) begin
                  // Chain straight into the next start bit when data waits.
                  if (fifo_empty) begin
                     state_d = StIdle;
                  end else begin
                     pop = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            line_d  = 1'b1;
         end
      endcase
      if (pop) begin
         shift_d   = fifo_head;
         bit_cnt_d = '0;
         state_d   = StStart;
         line_d    = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         line_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         line_q    <= line_d;
      end
   end

   assign TxWire      = line_q;
   assign TxReady     = !fifo_full;
   assign TxBusy      = (state_q != StIdle) || (fifo_count != '0);
   assign TxFifoCount = fifo_count;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench: two transmitter instances (8N1 depth 4, 5-bit 2-stop depth 2)
// checked cycle by cycle against a queue-based model of FIFO contents and line frames.
module tb_uart_tx_frame;

   localparam int unsigned ClkHz = 1_000_000;
   localparam int unsigned Baud  = 100_000;
   localparam int unsigned Div   = ClkHz / Baud;
`ifdef UART_TX_FRAME_PARITY_EN
   localparam bit ParityEn = 1'b1;
`else
   localparam bit ParityEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic       valid = 1'b0;
   logic [8:0] data = '0;

   logic       a_valid, a_wire, a_ready, a_busy;
   logic [2:0] a_count;
   logic       b_valid, b_wire, b_ready, b_busy;
   logic [1:0] b_count;

   logic       line_m, ready_m, busy_m;
   logic [3:0] count_m;

   assign a_valid = valid && !sel;
   assign b_valid = valid && sel;
   assign line_m  = sel ? b_wire : a_wire;
   assign ready_m = sel ? b_ready : a_ready;
   assign busy_m  = sel ? b_busy : a_busy;
   assign count_m = sel ? {2'b00, b_count} : {1'b0, a_count};

   always #5 clk = ~clk;

   uart_tx_frame #(
      .CLOCK_FREQUENCY (ClkHz),
      .BAUD_RATE       (Baud),
      .DATA_BITS       (8),
      .STOP_BITS       (1),
      .PARITY_ODD      (0),
      .FIFO_DEPTH      (4)
   ) dut_a (
      .Clk         (clk),
      .Reset       (rst_n),
      .TxWire      (a_wire),
      .TxDataInput (data[7:0]),
      .TxValid     (a_valid),
      .TxReady     (a_ready),
      .TxBusy      (a_busy),
      .TxFifoCount (a_count)
   );

   uart_tx_frame #(
      .CLOCK_FREQUENCY (ClkHz),
      .BAUD_RATE       (Baud),
      .DATA_BITS       (5),
      .STOP_BITS       (2),
      .PARITY_ODD      (1),
      .FIFO_DEPTH      (2)
   ) dut_b (
      .Clk         (clk),
      .Reset       (rst_n),
      .TxWire      (b_wire),
      .TxDataInput (data[4:0]),
      .TxValid     (b_valid),
      .TxReady     (b_ready),
      .TxBusy      (b_busy),
      .TxFifoCount (b_count)
   );

   // Model: characters waiting in the FIFO, and line levels still to come.
   bit          line_q[$];
   int unsigned mq[$];
   int unsigned depth_c, nbits_c, stop_c;
   bit          odd_c;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;

   function automatic void add_frame(input int unsigned c);
      bit par;
      par = odd_c;
      repeat (Div) line_q.push_back(1'b0);
      for (int i = 0; i < int'(nbits_c); i++) begin
         par ^= c[i];
         repeat (Div) line_q.push_back(c[i]);
      end
      if (ParityEn) repeat (Div) line_q.push_back(par);
      repeat (stop_c * Div) line_q.push_back(1'b1);
   endfunction

   task automatic use_dut(input bit s);
      sel     = s;
      depth_c = s ? 2 : 4;
      nbits_c = s ? 5 : 8;
      stop_c  = s ? 2 : 1;
      odd_c   = s;
      line_q.delete();
      mq.delete();
   endtask

   // Compare outputs at this negedge, then advance the model across the next posedge.
   task automatic step(input string name);
      bit          exp_line, exp_ready, exp_busy, acc;
      int unsigned exp_cnt;
      exp_line  = (line_q.size() != 0) ? line_q[0] : 1'b1;
      exp_cnt   = mq.size();
      exp_ready = (exp_cnt < depth_c);
      exp_busy  = (line_q.size() != 0) || (exp_cnt != 0);
      n_checks++;
      if (line_m !== exp_line) begin
         n_fail++;
         $display("FAIL %s cycle %0d: TxWire got %b expected %b", name, cyc, line_m, exp_line);
      end
      n_checks++;
      if (count_m !== 4'(exp_cnt)) begin
         n_fail++;
         $display("FAIL %s cycle %0d: TxFifoCount got %0d expected %0d", name, cyc, count_m,
                  exp_cnt);
      end
      n_checks++;
      if (ready_m !== exp_ready) begin
         n_fail++;
         $display("FAIL %s cycle %0d: TxReady got %b expected %b", name, cyc, ready_m, exp_ready);
      end
      n_checks++;
      if (busy_m !== exp_busy) begin
         n_fail++;
         $display("FAIL %s cycle %0d: TxBusy got %b expected %b", name, cyc, busy_m, exp_busy);
      end
      acc = valid && (exp_cnt < depth_c);
      if (line_q.size() != 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && mq.size() != 0) add_frame(mq.pop_front());
      if (acc) mq.push_back(int'(data) & ((1 << nbits_c) - 1));
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain(input string name);
      valid = 1'b0;
      for (int i = 0; i < 3000 && (line_q.size() != 0 || mq.size() != 0); i++) step(name);
      repeat (3) step(name);
   endtask

   task automatic push_seq(input string name, input int unsigned chars[$]);
      foreach (chars[i]) begin
         valid = 1'b1;
         data  = 9'(chars[i]);
         step(name);
      end
      valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks += 8;
      if (a_wire !== 1'b1) begin n_fail++; $display("FAIL reset a TxWire got %b expected 1", a_wire); end
      if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset a TxReady got %b expected 1", a_ready); end
      if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset a TxBusy got %b expected 0", a_busy); end
      if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset a TxFifoCount got %0d expected 0", a_count); end
      if (b_wire !== 1'b1) begin n_fail++; $display("FAIL reset b TxWire got %b expected 1", b_wire); end
      if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset b TxReady got %b expected 1", b_ready); end
      if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset b TxBusy got %b expected 0", b_busy); end
      if (b_count !== 2'd0) begin n_fail++; $display("FAIL reset b TxFifoCount got %0d expected 0", b_count); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_char();
      use_dut(1'b0);
      push_seq("single_55", '{32'h55});
      drain("single_55");
   endtask

   task automatic test_back_to_back();
      use_dut(1'b0);
      push_seq("back_to_back", '{32'hA3, 32'h0F, 32'hFF, 32'h00, $urandom_range(0, 255)});
      drain("back_to_back");
   endtask

   task automatic test_parity();
      use_dut(1'b0);
      push_seq("parity_07", '{32'h07});
      drain("parity_07");
      push_seq("parity_03", '{32'h03});
      drain("parity_03");
      use_dut(1'b1);
      push_seq("parity_odd", '{32'h07, 32'h03});
      drain("parity_odd");
   endtask

   task automatic test_width_stop();
      use_dut(1'b1);
      push_seq("width5_1f", '{32'h1F});
      drain("width5_1f");
      push_seq("width5_rand", '{$urandom_range(0, 31), $urandom_range(0, 31),
                                $urandom_range(0, 31)});
      drain("width5_rand");
   endtask

   task automatic test_random();
      for (int s = 0; s < 2; s++) begin
         use_dut(s[0]);
         repeat (60) begin
            valid = 1'($urandom_range(0, 1));
            data  = 9'($urandom);
            step("random");
         end
         drain("random");
      end
   endtask

   task automatic test_full_hold();
      for (int s = 0; s < 2; s++) begin
         use_dut(s[0]);
         valid = 1'b1;
         repeat (450) begin
            data = 9'($urandom);
            step("full_hold");
         end
         drain("full_hold");
      end
   endtask

   task automatic test_reset_mid_frame();
      use_dut(1'b0);
      push_seq("mid_reset", '{$urandom_range(0, 255) & 32'hF7, $urandom_range(0, 255),
                              $urandom_range(0, 255)});
      // Three pushes done; 44 more steps puts the line in the middle of data bit 3.
      repeat (44) step("mid_reset");
      rst_n = 1'b0;
      #1;
      n_checks += 4;
      if (a_wire !== 1'b1) begin n_fail++; $display("FAIL mid_reset TxWire got %b expected 1", a_wire); end
      if (a_count !== 3'd0) begin n_fail++; $display("FAIL mid_reset TxFifoCount got %0d expected 0", a_count); end
      if (a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset TxReady got %b expected 1", a_ready); end
      if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset TxBusy got %b expected 0", a_busy); end
      line_q.delete();
      mq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (200) step("after_reset");
   endtask

   initial begin
      use_dut(1'b0);
      test_reset();
      test_single_char();
      test_back_to_back();
      test_parity();
      test_width_stop();
      test_random();
      test_full_hold();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with configurable character width, stop-bit count and a TX FIFO. It sits between a byte/word producer (CPU bus bridge, debug streamer) and the board TX pin. It replaces the fixed 8N1 single-buffer transmitter. Back-to-back frames go out with no idle gap while the FIFO holds data.

## Interface
- CLOCK_FREQUENCY, 1_000_000: Clk frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
  - DIVISOR = CLOCK_FREQUENCY / BAUD_RATE, integer truncation.
  - DIVISOR must be ≥ 4.
- DATA_BITS, 8: character width, legal 5..9.
- STOP_BITS, 1: legal 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Only meaningful with the parity macro.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, ≥ 2.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low.
- TxWire  out  1  serial line, idle high.
- TxDataInput  in  DATA_BITS  character to send.
- TxValid  in  1  producer offers TxDataInput.
- TxReady  out  1  FIFO not full; a push occurs on an edge where TxValid && TxReady.
- TxBusy  out  1  a frame is on the line or the FIFO is non-empty.
- TxFifoCount  out  $clog2(FIFO_DEPTH)+1  number of entries held.

## Operation
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the index.
  - Full when the pointers differ only in the MSB.
- Push while full is ignored. TxReady=0 already signals this.
- Push and pop on the same edge (count 1..DEPTH-1): count unchanged, both pointers advance.
- Pop at empty never occurs; only the FSM pops.
- Baud tick generator:
  - Counter 0..DIVISOR-1, cleared on entry to START.
  - BitTick is one cycle wide when the counter equals DIVISOR-1; the counter then wraps to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register, clear the bit counter, go to START, drive TxWire<=0.
  - START: on BitTick go to DATA, drive TxWire<=shift[0].
  - DATA:
    - On each BitTick, shift right and increment the bit counter.
    - After DATA_BITS ticks, go to PARITY if the macro is enabled, otherwise go to STOP.
    - Drive the next bit / parity bit / 1 accordingly.
  - PARITY: on BitTick go to STOP, TxWire<=1.
  - STOP:
    - Count STOP_BITS ticks.
    - On the last tick: if FIFO non-empty, pop, go directly to START and drive TxWire<=0 (no idle gap). Otherwise go to IDLE with TxWire=1.
- Bit order: LSB first.
- TxBusy = (state != IDLE) || (count != 0).

## Timing
- Reset values:
  - TxWire=1, TxReady=1, TxBusy=0, TxFifoCount=0.
  - FSM in IDLE, pointers 0, baud counter 0.
- Reset mid-frame: TxWire returns to 1 asynchronously and all FIFO contents are discarded.
- Push accepted at edge N into an idle block: TxFifoCount=1 after N; pop and TxWire falling at edge N+1. Latency is 1 cycle.
- Each line bit, including the start bit, is held for exactly DIVISOR cycles.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × DIVISOR cycles, where P = 1 with parity, else 0.
- TxReady is combinational from the registered count; it rises in the cycle after a pop from a full FIFO.
- TxWire is always driven from a flop (glitch-free).

## Configuration
- UART_TX_FRAME_PARITY_EN defined:
  - PARITY state is present.
  - Parity bit = ^data for even parity, ~^data when PARITY_ODD=1.
- Not defined:
  - PARITY state and parity logic are absent; DATA goes straight to STOP.
  - PARITY_ODD is ignored.

## Structure
- Shared header: FSM state encodings (3 bits), the DIVISOR computation macro and legal-range checks for DATA_BITS/STOP_BITS. The receive side reuses these.
- One sub-module: uart_baud_tick, the DIVISOR counter with synchronous clear and a one-cycle tick output. The FIFO stays inline.

## Test plan
- CLOCK_FREQUENCY=1_000_000, BAUD_RATE=100_000 (DIVISOR=10), 8N1. Push 0x55 → TxWire low at push+1, then 1,0,1,0,1,0,1,0,1 each 10 cycles; frame 100 cycles; TxBusy falls afterwards.
- Push 0xA3, 0x0F, 0xFF, 0x00 in consecutive cycles → TxReady=0 while count=4. Four frames go out with no idle cycle between a stop bit and the next start bit, in push order.
- Parity macro with PARITY_ODD=0 and DATA_BITS=8. Push 0x07 → parity bit 1. Push 0x03 → parity bit 0. With PARITY_ODD=1 the parity bits invert.
- DATA_BITS=5, STOP_BITS=2. Push 0x1F → five 1s, then 20 cycles high; frame 80 cycles.
- Assert Reset during bit 3 of a frame with 2 entries queued → TxWire=1 immediately, TxFifoCount=0. After release, no further frame starts.
- Full FIFO with TxValid held high continuously → exactly one new entry accepted per pop. TxFifoCount never exceeds FIFO_DEPTH.
